// File: rtl/alu_core.sv
// alu_core: ALU execution stage.
// Accepts one operation per valid/ready handshake, computes add/and/xor in a
// single cycle or an unsigned multiply by iterative shift-add, and presents a
// 2W-bit registered result together with a one-cycle done pulse.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      hard reset, asynchronous, active-low
//   alu_rst_i  soft reset, synchronous, active-high (aborts, clears result)
//   valid_i    request, qualified by ready_o
//   op_i       opcode: 0 no_op, 1 add, 2 and, 3 xor, 4 mul, 5..7 reserved
//   a_i, b_i   unsigned operands, captured on acceptance
//   ready_o    stage can accept a request (registered)
//   done_o     one-cycle pulse: result_o has just been loaded
//   result_o   result of the last completed operation, held until next one
module alu_core #(
  parameter int ALU_IN_OP_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           alu_rst_i,
  input  logic                           valid_i,
  input  logic [2:0]                     op_i,
  input  logic [ALU_IN_OP_WIDTH-1:0]     a_i,
  input  logic [ALU_IN_OP_WIDTH-1:0]     b_i,
  output logic                           ready_o,
  output logic                           done_o,
  output logic [2*ALU_IN_OP_WIDTH-1:0]   result_o
);

  localparam int W  = ALU_IN_OP_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  state_t          state_reg,  state_next;
  logic [2:0]      op_reg,     op_next;
  // opa doubles as the multiplicand, so it is 2W wide to absorb the shifts.
  logic [2*W-1:0]  opa_reg,    opa_next;
  // opb doubles as the multiplier, shifted right each MUL cycle.
  logic [W-1:0]    opb_reg,    opb_next;
  logic [2*W-1:0]  acc_reg,    acc_next;
  logic [CW-1:0]   cnt_reg,    cnt_next;
  // Set after the final iteration; the product is published one cycle later,
  // which gives W iterations plus one completion cycle.
  logic            fin_reg,    fin_next;
  logic            ready_reg,  ready_next;
  logic            done_reg,   done_next;
  logic [2*W-1:0]  result_reg, result_next;

  logic [W:0]      sum_w;
  logic            accept;

  assign sum_w  = {1'b0, opa_reg[W-1:0]} + {1'b0, opb_reg};
  // ready_reg is only ever 1 in IDLE, so it also qualifies the state.
  assign accept = valid_i && ready_reg && !alu_rst_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      fin_reg    <= 1'b0;
      ready_reg  <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      fin_reg    <= fin_next;
      ready_reg  <= ready_next;
      done_reg   <= done_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    opa_next    = opa_reg;
    opb_next    = opb_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    fin_next    = fin_reg;
    ready_next  = ready_reg;
    done_next   = 1'b0;
    result_next = result_reg;

    if (alu_rst_i) begin
      state_next  = ST_IDLE;
      acc_next    = '0;
      cnt_next    = '0;
      fin_next    = 1'b0;
      ready_next  = 1'b0;
      result_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ready_next = 1'b1;
          if (accept) begin
            case (op_i)
              OP_ADD, OP_AND, OP_XOR: begin
                op_next    = op_i;
                opa_next   = {{W{1'b0}}, a_i};
                opb_next   = b_i;
                state_next = ST_EXEC;
                ready_next = 1'b0;
              end
              OP_MUL: begin
                op_next    = op_i;
                opa_next   = {{W{1'b0}}, a_i};
                opb_next   = b_i;
                acc_next   = '0;
                cnt_next   = CW'(W - 1);
                fin_next   = 1'b0;
                state_next = ST_MUL;
                ready_next = 1'b0;
              end
              default: ;  // no_op and reserved codes are consumed silently
            endcase
          end
        end

        ST_EXEC: begin
          case (op_reg)
            OP_ADD:  result_next = {{(W-1){1'b0}}, sum_w};
            OP_AND:  result_next = {{W{1'b0}}, opa_reg[W-1:0] & opb_reg};
            OP_XOR:  result_next = {{W{1'b0}}, opa_reg[W-1:0] ^ opb_reg};
            default: result_next = '0;
          endcase
          done_next  = 1'b1;
          ready_next = 1'b1;
          state_next = ST_IDLE;
        end

        ST_MUL: begin
          if (fin_reg) begin
            result_next = acc_reg;
            done_next   = 1'b1;
            ready_next  = 1'b1;
            fin_next    = 1'b0;
            state_next  = ST_IDLE;
          end else begin
            if (opb_reg[0]) begin
              acc_next = acc_reg + opa_reg;
            end
            opa_next = opa_reg << 1;
            opb_next = opb_reg >> 1;
            if (cnt_reg == '0) begin
              fin_next = 1'b1;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o  = ready_reg;
  assign done_o   = done_reg;
  assign result_o = result_reg;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed self-checking bench for alu_core with W = 8.
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// at the same point, i.e. reflecting the edge just taken.
module tb_alu_core;

  localparam int W = 8;

  logic             clk_i;
  logic             rst_i;
  logic             alu_rst_i;
  logic             valid_i;
  logic [2:0]       op_i;
  logic [W-1:0]     a_i;
  logic [W-1:0]     b_i;
  logic             ready_o;
  logic             done_o;
  logic [2*W-1:0]   result_o;

  int n_cmp = 0;
  int n_err = 0;

  alu_core #(.ALU_IN_OP_WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .alu_rst_i(alu_rst_i),
    .valid_i  (valid_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Single-cycle op: accept at N, result/done at N+1, done gone at N+2.
  task automatic do_simple(input string tag, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [15:0] exp);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    step();                                  // edge N
    valid_i = 1'b0; a_i = W'($urandom); b_i = W'($urandom);
    chk({tag, ".rdyN"}, {31'd0, ready_o}, 32'd0);
    chk({tag, ".dnN"},  {31'd0, done_o},  32'd0);
    step();                                  // edge N+1
    chk({tag, ".res"},  {16'd0, result_o}, {16'd0, exp});
    chk({tag, ".dn1"},  {31'd0, done_o},   32'd1);
    chk({tag, ".rdy1"}, {31'd0, ready_o},  32'd1);
    step();                                  // edge N+2
    chk({tag, ".dn2"},  {31'd0, done_o},   32'd0);
    chk({tag, ".hold"}, {16'd0, result_o}, {16'd0, exp});
  endtask

  // Multiply: ready low over N..N+8, result/done at N+9 only.
  task automatic do_mul(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [15:0] exp);
    valid_i = 1'b1; op_i = 3'd4; a_i = a; b_i = b;
    step();                                  // edge N
    valid_i = 1'b0; a_i = ~a; b_i = ~b;
    chk({tag, ".rdyN"}, {31'd0, ready_o}, 32'd0);
    for (int k = 1; k <= W; k++) begin
      step();
      chk({tag, ".busy"}, {30'd0, ready_o, done_o}, 32'd0);
    end
    step();                                  // edge N+W+1
    chk({tag, ".res"},  {16'd0, result_o}, {16'd0, exp});
    chk({tag, ".dn"},   {31'd0, done_o},   32'd1);
    chk({tag, ".rdy"},  {31'd0, ready_o},  32'd1);
    step();
    chk({tag, ".dnoff"}, {31'd0, done_o},  32'd0);
  endtask

  initial begin
    rst_i = 1'b0; alu_rst_i = 1'b0; valid_i = 1'b0;
    op_i = 3'd0; a_i = '0; b_i = '0;

    // Reset state and release
    #1;
    chk("rst.ready",  {31'd0, ready_o},  32'd0);
    chk("rst.done",   {31'd0, done_o},   32'd0);
    chk("rst.result", {16'd0, result_o}, 32'd0);
    step(); step();
    rst_i = 1'b1;
    step();
    chk("rel.ready",  {31'd0, ready_o},  32'd1);
    chk("rel.done",   {31'd0, done_o},   32'd0);

    // Add with carry
    do_simple("add", 3'd1, 8'hFF, 8'h01, 16'h0100);

    // Multiply variants
    do_mul("mulFF", 8'hFF, 8'hFF, 16'hFE01);
    do_mul("mulA0", 8'h00, 8'hFF, 16'h0000);
    do_mul("mulB1", 8'hFF, 8'h01, 16'h00FF);

    // Back-to-back: and at N, mul request at N+1 must be ignored, xor at N+2
    valid_i = 1'b1; op_i = 3'd2; a_i = 8'hF0; b_i = 8'h3C;
    step();                                  // N
    op_i = 3'd4; a_i = 8'h03; b_i = 8'h03;   // valid stays high
    step();                                  // N+1
    chk("b2b.and",   {16'd0, result_o}, 32'h0030);
    chk("b2b.dn1",   {31'd0, done_o},   32'd1);
    chk("b2b.rdy1",  {31'd0, ready_o},  32'd1);
    op_i = 3'd3; a_i = 8'hF0; b_i = 8'h3C;
    step();                                  // N+2
    valid_i = 1'b0;
    chk("b2b.rdy2",  {31'd0, ready_o},  32'd0);
    step();                                  // N+3
    chk("b2b.xor",   {16'd0, result_o}, 32'h00CC);
    chk("b2b.dn3",   {31'd0, done_o},   32'd1);
    step();
    chk("b2b.dn4",   {31'd0, done_o},   32'd0);

    // Soft reset at N+3 of a multiply, with a simultaneous request
    valid_i = 1'b1; op_i = 3'd4; a_i = 8'h12; b_i = 8'h34;
    step();                                  // N
    valid_i = 1'b0;
    step(); step();                          // N+1, N+2
    alu_rst_i = 1'b1; valid_i = 1'b1; op_i = 3'd1; a_i = 8'h01; b_i = 8'h01;
    step();                                  // N+3
    chk("srst.result", {16'd0, result_o}, 32'd0);
    chk("srst.done",   {31'd0, done_o},   32'd0);
    chk("srst.ready",  {31'd0, ready_o},  32'd0);
    alu_rst_i = 1'b0; valid_i = 1'b0;
    step();                                  // N+4
    chk("srst.rdyback", {31'd0, ready_o}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("srst.quiet", {15'd0, done_o, result_o}, 32'd0);
    end

    // No-op and reserved opcodes on consecutive cycles
    do_simple("xor5", 3'd3, 8'h0F, 8'h05, 16'h000A);
    valid_i = 1'b1; op_i = 3'd0; a_i = 8'h11; b_i = 8'h22;
    step();
    chk("nop.state",  {14'd0, ready_o, done_o, result_o}, {14'd0, 2'b10, 16'h000A});
    op_i = 3'd6;
    step();
    chk("rsv.state",  {14'd0, ready_o, done_o, result_o}, {14'd0, 2'b10, 16'h000A});
    valid_i = 1'b0;
    step();
    chk("rsv.after",  {14'd0, ready_o, done_o, result_o}, {14'd0, 2'b10, 16'h000A});

    // Hard reset mid-multiply, asynchronous
    valid_i = 1'b1; op_i = 3'd4; a_i = 8'hFF; b_i = 8'hFF;
    step();
    valid_i = 1'b0;
    step(); step();
    #2;
    rst_i = 1'b0;
    #1;
    chk("hrst.ready",  {31'd0, ready_o},  32'd0);
    chk("hrst.done",   {31'd0, done_o},   32'd0);
    chk("hrst.result", {16'd0, result_o}, 32'd0);
    step();
    rst_i = 1'b1;
    step();
    chk("hrst.rdyback", {31'd0, ready_o}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hrst.quiet", {15'd0, done_o, result_o}, 32'd0);
    end

    // Operation still works after the hard reset
    do_simple("add2", 3'd1, 8'h80, 8'h80, 16'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_core.md
# alu_core

Execution stage of the ALU. It accepts one operation per valid/ready handshake on the `alu_in` bus (`valid`, `op`, `a`, `b`, `ready`, `alu_rst`). It computes add, and, xor, or unsigned multiply, and presents a `2*ALU_IN_OP_WIDTH`-bit result with a one-cycle `done_o` pulse to the `alu_out` monitoring side. Simple ops complete in one cycle; multiply is iterative shift-add.

## Interface
- `ALU_IN_OP_WIDTH`, default 8: operand width W. Legal range is 2..32.
- `clk_i`  input  1  Clock. All logic is rising-edge.
- `rst_i`  input  1  Reset, asynchronous, active-low.
- `alu_rst_i`  input  1  Synchronous soft reset, active-high.
- `valid_i`  input  1  Operation request, qualified by `ready_o`.
- `op_i`  input  3  Opcode: 0 = no_op, 1 = add, 2 = and, 3 = xor, 4 = mul, 5..7 = reserved.
- `a_i`  input  W  Operand A, unsigned.
- `b_i`  input  W  Operand B, unsigned.
- `ready_o`  output  1  Stage can accept a request.
- `done_o`  output  1  One-cycle pulse: `result_o` is valid.
- `result_o`  output  2W  Result of the last completed operation.

## Operation
- **Acceptance:** a request is accepted at a rising edge where `valid_i` = 1, `ready_o` = 1 and `alu_rst_i` = 0.
  - `op_i`, `a_i` and `b_i` are captured at that edge.
  - Later changes on these inputs are ignored until the next acceptance.
  - `valid_i` while `ready_o` = 0 is ignored and never queued. X on `op_i`/`a_i`/`b_i` while not accepting is ignored.
- **States:**
  - IDLE: `ready_o` = 1.
  - EXEC: add, and, xor.
  - MUL: iterative multiply, down-counter of W iterations.
- **Transitions:**
  - IDLE + accept of op 1/2/3 -> EXEC.
  - IDLE + accept of op 4 -> MUL. Counter = W-1, accumulator = 0, multiplicand = zero-extended a, multiplier = b.
  - IDLE + accept of op 0 or 5..7 -> stays IDLE. No result, no `done_o`, `ready_o` stays 1.
  - EXEC -> IDLE after one cycle.
  - MUL: each cycle, if multiplier LSB = 1, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1. When the counter is 0 -> IDLE, else counter decrements.
- **Result widths:**
  - add: `{(W-1)'b0, carry, sum[W-1:0]}`, i.e. a + b zero-extended to 2W.
  - and, xor: zero-extended to 2W.
  - mul: full 2W unsigned product. It cannot overflow.
- **Completion:** on leaving EXEC or MUL, `result_o` is loaded and `done_o` = 1 for exactly one cycle. `ready_o` returns to 1 in that same cycle.
- **Result hold:** `result_o` holds its value until the next completion or a reset. It is not cleared when `done_o` drops.
- **Soft reset (`alu_rst_i` = 1 at an edge):**
  - Aborts any operation and forces IDLE.
  - `done_o` = 0, `result_o` = 0, `ready_o` = 0.
  - It has priority over a simultaneous `valid_i`, which is then not accepted.
  - `ready_o` returns to 1 at the first edge where `alu_rst_i` = 0.
- **Hard reset (`rst_i` = 0):** immediate, at any time including mid-multiply. State IDLE, `ready_o` = 0, `done_o` = 0, `result_o` = 0, internal registers = 0.
- **Hard reset release:** `ready_o` = 1 at the first rising edge with `rst_i` = 1 and `alu_rst_i` = 0.

## Timing
- Accept at edge N. `ready_o` falls after edge N for op 1..4.
- add/and/xor: `result_o` and `done_o` update at edge N+1. `ready_o` = 1 from N+1. The earliest next accept is edge N+2, so throughput is 1 op per 2 cycles.
- mul: `ready_o` = 0 from N to N+W. `result_o` and `done_o` update at edge N+W+1, which is N+9 for W = 8. The earliest next accept is N+W+2.
- no_op/reserved: no effect on `ready_o`. Back-to-back accepts every cycle are legal.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** drive `rst_i` = 0 mid-multiply.
  - Required: `ready_o`, `done_o` and `result_o` go to 0 immediately, without waiting for a clock edge.
  - Release `rst_i` -> `ready_o` = 1 after the first edge, and no stale `done_o` appears.
- **Add with carry:** W = 8, a = 0xFF, b = 0x01, op 1 accepted at N.
  - Required: `result_o` = 0x0100 and `done_o` = 1 at N+1 only, `ready_o` = 1 at N+1.
- **Multiply:** a = 0xFF, b = 0xFF, op 4 at N.
  - Required: `ready_o` = 0 over N..N+8, `result_o` = 0xFE01, `done_o` = 1 at N+9 only.
  - Repeat with a = 0x00 -> result 0x0000. Repeat with b = 0x01 -> result 0x00FF.
- **Back-to-back simple ops:** and 0xF0/0x3C at N, xor 0xF0/0x3C at N+2.
  - Required: 0x0030 at N+1, then 0x00CC at N+3.
  - `valid_i` held high at N+1 is ignored.
- **Soft reset mid-multiply:** `alu_rst_i` pulsed at N+3 of a multiply, with `valid_i` = 1 at the same edge.
  - Required: no `done_o`, `result_o` = 0, request not accepted, `ready_o` = 1 one edge after `alu_rst_i` drops.
- **No-op and reserved opcodes:** op 0 and op 6 accepted on consecutive cycles.
  - Required: no `done_o`, `ready_o` stays 1, `result_o` unchanged from the prior value.
